// File: rtl/output_wrapper.sv
// Serialises one 2*WORD_W-bit core result into two WORD_W-bit bus words, high word first.
// Defining OUTWRAP_OVF_EN adds a sticky ovf flag for results that arrive while busy.
module output_wrapper #(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resultValid,
    input  logic [2*WORD_W-1:0]   result,
    output logic                  oBufferReady,
    output logic [WORD_W-1:0]     outBus,
    output logic                  dataReady,
    input  logic                  dataAccept,
    output logic [7:0]            sentCount
`ifdef OUTWRAP_OVF_EN
    ,
    output logic                  ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [2*WORD_W-1:0] held_reg;
    logic [7:0]          sent_count_reg;
    logic                load_en;
    logic                count_en;

    // Outputs decode purely from the present state, so reset takes effect on them immediately.
    always_comb begin
        state_next   = state_reg;
        oBufferReady = 1'b0;
        dataReady    = 1'b0;
        outBus       = '0;
        load_en      = 1'b0;
        count_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                oBufferReady = 1'b1;
                if (resultValid) begin
                    load_en    = 1'b1;
                    state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                dataReady = 1'b1;
                outBus    = held_reg[2*WORD_W-1:WORD_W];
                if (dataAccept) begin
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                dataReady = 1'b1;
                outBus    = held_reg[WORD_W-1:0];
                if (dataAccept) begin
                    count_en   = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_reg <= '0;
        end else if (load_en) begin
            held_reg <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_count_reg <= 8'd0;
        end else if (count_en) begin
            sent_count_reg <= sent_count_reg + 8'd1;
        end
    end

    assign sentCount = sent_count_reg;

`ifdef OUTWRAP_OVF_EN
    logic ovf_reg;

    // A result offered outside IDLE is lost; remember that until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (resultValid && (state_reg != IDLE)) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_output_wrapper.sv
// Directed bench for output_wrapper: stimulus queues expected bus words, a monitor
// pops and compares them on every accepted transfer; cycle checks cover status outputs.
module tb_output_wrapper;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             resultValid;
    logic [2*W-1:0]   result;
    logic             oBufferReady;
    logic [W-1:0]     outBus;
    logic             dataReady;
    logic             dataAccept;
    logic [7:0]       sentCount;
`ifdef OUTWRAP_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    output_wrapper #(.WORD_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .resultValid  (resultValid),
        .result       (result),
        .oBufferReady (oBufferReady),
        .outBus       (outBus),
        .dataReady    (dataReady),
        .dataAccept   (dataAccept),
        .sentCount    (sentCount)
`ifdef OUTWRAP_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle resultValid pulse; returns just after the capture edge.
    task automatic send_result(input logic [2*W-1:0] value);
        resultValid = 1'b1;
        result      = value;
        exp_q.push_back(value[2*W-1:W]);
        exp_q.push_back(value[W-1:0]);
        step();
        resultValid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_rdy"},   64'(oBufferReady), 64'd1);
        check({name, "_dv"},    64'(dataReady),    64'd0);
        check({name, "_bus"},   64'(outBus),       64'd0);
    endtask

    // Monitor: a word moves on an edge where dataReady and dataAccept are both high.
    always @(negedge clk) begin
        if (dataReady && dataAccept) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(outBus), 64'hDEAD);
            end else begin
                check("bus_word", 64'(outBus), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        resultValid = 1'b0;
        result      = '0;
        dataAccept  = 1'b0;
        step();
        step();
        check_idle("reset");
        check("reset_cnt", 64'(sentCount), 64'd0);
        rst = 1'b0;
        step();

        // Reset while the low word is on the bus aborts the transfer.
        send_result(64'h1122334455667788);
        dataAccept = 1'b1;
        step();
        dataAccept = 1'b0;
        check("slo_dv", 64'(dataReady), 64'd1);
        check("slo_bus", 64'(outBus), 64'h55667788);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_idle("rst_mid");
        check("rst_mid_cnt", 64'(sentCount), 64'd0);
        step();
        rst = 1'b0;
        dataAccept = 1'b1;
        step();
        step();
        step();
        check_idle("no_resume");
        check("no_resume_cnt", 64'(sentCount), 64'd0);

        // Streaming case with dataAccept held high.
        send_result(64'h1122334455667788);
        check("c1_dv", 64'(dataReady), 64'd1);
        check("c1_bus", 64'(outBus), 64'h11223344);
        check("c1_rdy", 64'(oBufferReady), 64'd0);
        step();
        check("c2_bus", 64'(outBus), 64'h55667788);
        step();
        check("c3_dv", 64'(dataReady), 64'd0);
        check("c3_rdy", 64'(oBufferReady), 64'd0);
        check("c3_bus", 64'(outBus), 64'd0);
        step();
        check("c4_rdy", 64'(oBufferReady), 64'd1);
        check("c4_cnt", 64'(sentCount), 64'd1);

        // Five stall cycles in SEND_HI.
        dataAccept = 1'b0;
        send_result(64'h1122334455667788);
        for (int i = 0; i < 5; i++) begin
            check("stall_bus", 64'(outBus), 64'h11223344);
            check("stall_dv", 64'(dataReady), 64'd1);
            step();
        end
        check("stall_held", 64'(outBus), 64'h11223344);
        dataAccept = 1'b1;
        step();
        check("stall_lo", 64'(outBus), 64'h55667788);
        step();
        step();
        check("stall_cnt", 64'(sentCount), 64'd2);

        // A result offered in SEND_LO is dropped.
        send_result(64'h1122334455667788);
        step();
        resultValid = 1'b1;
        result      = 64'hAAAAAAAAAAAAAAAA;
        step();
        resultValid = 1'b0;
        check("drop_gap_dv", 64'(dataReady), 64'd0);
`ifdef OUTWRAP_OVF_EN
        check("ovf_set", 64'(ovf), 64'd1);
`endif
        step();
        check("drop_cnt", 64'(sentCount), 64'd3);
        check("drop_rdy", 64'(oBufferReady), 64'd1);

        // 256 then 257 back-to-back results from a cleared counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef OUTWRAP_OVF_EN
        check("ovf_clr", 64'(ovf), 64'd0);
`endif
        for (int i = 0; i < 256; i++) begin
            send_result({32'(i), ~32'(i)});
            step();
            step();
            step();
        end
        check("wrap_256", 64'(sentCount), 64'd0);
        send_result(64'hCAFEF00D12345678);
        step();
        step();
        step();
        check("wrap_257", 64'(sentCount), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_wrapper.md
OUTPUT_WRAPPER -- requirements
Module: output_wrapper

Interface
REQ-001 Parameter: WORD_W, default 32, width of each bus word; the result is 2*WORD_W bits.
REQ-002 Signal: clk  input  1  rising-edge clock.
REQ-003 Signal: rst  input  1  reset; asynchronous, active-high.
REQ-004 Signal: resultValid  input  1  one-cycle pulse from the compute core meaning result is valid.
REQ-005 Signal: result  input  2*WORD_W  core result; sampled only when resultValid is high.
REQ-006 Signal: oBufferReady  output  1  buffer empty, can accept a result (goes to the input-side wrapper).
REQ-007 Signal: outBus  output  WORD_W  outgoing data word.
REQ-008 Signal: dataReady  output  1  word on outBus is valid.
REQ-009 Signal: dataAccept  input  1  consumer takes the current word.
REQ-010 Signal: sentCount  output  8  number of results fully sent; wraps modulo 256.
REQ-011 Signal: ovf  output  1  sticky overflow flag; present only when OUTWRAP_OVF_EN is defined.

Function
REQ-012 The block SHALL be a registered FSM with four states, whose outputs decode from the present state:
- IDLE
- SEND_HI
- SEND_LO
- GAP
REQ-013 In IDLE, outputs SHALL be oBufferReady=1, dataReady=0 and outBus=0.
REQ-014 In IDLE, when resultValid=1, result SHALL be captured into a 2*WORD_W holding register at that edge and the next state SHALL be SEND_HI.
REQ-015 In SEND_HI:
- outputs SHALL be dataReady=1, outBus=held[2*WORD_W-1:WORD_W], oBufferReady=0;
- the state SHALL advance to SEND_LO on the edge where dataAccept=1, otherwise hold.
REQ-016 In SEND_LO:
- outputs SHALL be dataReady=1, outBus=held[WORD_W-1:0], oBufferReady=0;
- on dataAccept=1 the state SHALL advance to GAP and sentCount SHALL increment, otherwise hold.
REQ-017 GAP SHALL last exactly one cycle, with dataReady=0, oBufferReady=0 and outBus=0, then go to IDLE.
REQ-018 A word SHALL be transferred only on a cycle where dataReady and dataAccept are both high.
REQ-019 dataAccept while dataReady=0 SHALL be ignored.
REQ-020 outBus SHALL stay stable while dataReady=1 and dataAccept=0, for any number of stall cycles.
REQ-021 Minimum result-to-result latency: capture edge plus 4 cycles, with dataAccept held high.
REQ-022 resultValid in SEND_HI, SEND_LO or GAP SHALL be dropped; the holding register SHALL be unchanged.
REQ-023 sentCount SHALL wrap from 255 to 0 without any side effect.
REQ-024 The holding register SHALL load only in IDLE.

Reset
REQ-025 When rst is asserted, the block SHALL immediately enter IDLE and clear the holding register, sentCount and ovf, including during a transfer.
REQ-026 During and after reset, outputs SHALL be oBufferReady=1, dataReady=0 and outBus=0.
REQ-027 A transfer cut off by reset SHALL NOT be resumed, and sentCount SHALL NOT count it.

Configuration
REQ-028 When OUTWRAP_OVF_EN is defined:
- port ovf SHALL exist;
- ovf SHALL be set on the edge after resultValid=1 in any state other than IDLE;
- ovf SHALL stay set until rst.
REQ-029 When OUTWRAP_OVF_EN is undefined, port ovf and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-030 With dataAccept=1 held, a resultValid pulse with result=0x11223344_55667788 SHALL produce:
- cycle+1: dataReady=1, outBus=0x11223344;
- cycle+2: outBus=0x55667788;
- cycle+3: dataReady=0;
- cycle+4: oBufferReady=1 and sentCount=1.
REQ-031 With dataAccept low for 5 cycles during SEND_HI, outBus SHALL hold 0x11223344 for all 5 cycles and no state change SHALL occur.
REQ-032 A resultValid pulse with result=0xAAAA... during SEND_LO SHALL leave the low word sent as 0x55667788, and ovf SHALL become 1 when OUTWRAP_OVF_EN is defined.
REQ-033 rst asserted in SEND_LO SHALL give dataReady=0 and oBufferReady=1 immediately, with sentCount unchanged at 0 for the first result.
REQ-034 After 256 back-to-back results, sentCount SHALL read 0, and 257 results SHALL give sentCount=1.
